// File: rtl/i2c_register_sequencer.sv
// i2c_register_sequencer: 16-bit-pointer register reads (pointer write, then burst read) through a shared i2c_controller.
// Optional transaction watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_register_sequencer #(
    parameter logic [6:0] DEVICE_ADDR = 7'h33,
    parameter int LEN_W = 12
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_reg_addr,
    input  logic [LEN_W-1:0] cmd_length,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             error,
    output logic             busy,
    input  logic             i2c_idle,
    input  logic             i2c_ack,
    input  logic             i2c_nack,
    input  logic [7:0]       i2c_received_data,
    output logic [6:0]       i2c_address,
    output logic             i2c_read_write,
    output logic [7:0]       i2c_transmit_data,
    output logic             i2c_enable_transfer
);
    typedef enum logic [2:0] {IDLE, WR_PTR, WR_WAIT, RD_DATA, RD_WAIT, FINISH, ABORT} state_t;

    state_t           state, state_n;
    logic [15:0]      addr_q, addr_n;
    logic [LEN_W-1:0] len_q, len_n, cnt, cnt_n;
    logic [7:0]       tx_q, tx_n, rd_data_q, rd_data_n;
    logic             ack_q, en_q, en_n, rw_q, rw_n, rd_valid_q, rd_valid_n;
    logic             error_q, error_n, seen_busy, seen_n, ptr_sel, ptr_n;
    logic             ack_rise, active, last;

    assign ack_rise = i2c_ack & ~ack_q;
    assign active = (state == WR_PTR) || (state == WR_WAIT) || (state == RD_DATA) || (state == RD_WAIT);
    assign last = ((state == WR_PTR) && ptr_sel) || ((state == RD_DATA) && (cnt == LEN_W'(1)));

    // The controller samples enable in the ack cycle, so drop it there to get a STOP after the last byte.
    assign i2c_enable_transfer = en_q & ~(ack_rise & last);
    assign cmd_ready = state == IDLE;
    assign busy = active || (state == ABORT);
    assign done = state == FINISH;
    assign error = error_q;
    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;
    assign i2c_address = DEVICE_ADDR;
    assign i2c_read_write = rw_q;
    assign i2c_transmit_data = tx_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [16:0] wdog;
    logic        timeout;
    assign timeout = wdog == 17'(TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || state_n != state || ack_rise)
            wdog <= '0;
        else
            wdog <= wdog + 17'd1;
    end
`endif

    always_comb begin
        state_n = state;
        addr_n = addr_q;
        len_n = len_q;
        cnt_n = cnt;
        tx_n = tx_q;
        rw_n = rw_q;
        en_n = en_q;
        rd_data_n = rd_data_q;
        rd_valid_n = 1'b0;
        error_n = 1'b0;
        seen_n = seen_busy | ~i2c_idle;
        ptr_n = ptr_sel;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_n = cmd_reg_addr;
                len_n = cmd_length;
                rw_n = 1'b0;
                tx_n = cmd_reg_addr[15:8];
                en_n = 1'b1;
                ptr_n = 1'b0;
                state_n = WR_PTR;
            end
            WR_PTR: if (ack_rise) begin
                tx_n = ptr_sel ? tx_q : addr_q[7:0];
                ptr_n = 1'b1;
                en_n = ~ptr_sel;
                seen_n = ~i2c_idle;
                state_n = ptr_sel ? WR_WAIT : WR_PTR;
            end
            WR_WAIT: if (seen_busy && i2c_idle) begin
                rw_n = len_q != '0;
                en_n = len_q != '0;
                cnt_n = len_q;
                state_n = (len_q == '0) ? FINISH : RD_DATA;
            end
            RD_DATA: if (ack_rise) begin
                rd_data_n = i2c_received_data;
                rd_valid_n = 1'b1;
                cnt_n = cnt - 1'b1;
                en_n = ~last;
                seen_n = ~i2c_idle;
                state_n = last ? RD_WAIT : RD_DATA;
            end
            RD_WAIT: state_n = (seen_busy && i2c_idle) ? FINISH : RD_WAIT;
            FINISH: state_n = IDLE;
            ABORT: if (seen_busy && i2c_idle) begin
                error_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A nack overrides any byte event seen in the same cycle.
        if (active && i2c_nack) begin
            en_n = 1'b0;
            cnt_n = '0;
            rd_valid_n = 1'b0;
            rd_data_n = rd_data_q;
            seen_n = ~i2c_idle;
            state_n = ABORT;
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        if (timeout && state == ABORT) begin
            error_n = 1'b1;
            state_n = IDLE;
        end else if (timeout && active) begin
            en_n = 1'b0;
            cnt_n = '0;
            seen_n = 1'b1;
            state_n = ABORT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            addr_q <= '0;
            len_q <= '0;
            cnt <= '0;
            tx_q <= '0;
            rw_q <= 1'b0;
            en_q <= 1'b0;
            ack_q <= 1'b0;
            rd_data_q <= '0;
            rd_valid_q <= 1'b0;
            error_q <= 1'b0;
            seen_busy <= 1'b0;
            ptr_sel <= 1'b0;
        end else begin
            state <= state_n;
            addr_q <= addr_n;
            len_q <= len_n;
            cnt <= cnt_n;
            tx_q <= tx_n;
            rw_q <= rw_n;
            en_q <= en_n;
            ack_q <= i2c_ack;
            rd_data_q <= rd_data_n;
            rd_valid_q <= rd_valid_n;
            error_q <= error_n;
            seen_busy <= (state_n == state) ? seen_n : ~i2c_idle;
            ptr_sel <= ptr_n;
        end
    end
endmodule

// File: tb/tb_i2c_register_sequencer.sv
// tb_i2c_register_sequencer: directed bench with a behavioural i2c_controller/peripheral model and tx/rd scoreboards.
module tb_i2c_register_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_reg_addr = '0;
    logic [11:0] cmd_length = '0;
    logic        cmd_ready, rd_valid, done, error, busy;
    logic [7:0]  rd_data;
    logic        i2c_idle = 1'b1, i2c_ack = 1'b0, i2c_nack = 1'b0;
    logic [7:0]  i2c_received_data = '0;
    logic [6:0]  i2c_address;
    logic        i2c_read_write, i2c_enable_transfer;
    logic [7:0]  i2c_transmit_data;

    int total = 0, bad = 0;
    logic [7:0] exp_tx[$], exp_rd[$], rd_src[$];
    int done_cnt = 0, err_cnt = 0, rv_cnt = 0, wr_total = 0, rd_total = 0, wr_txns = 0, rd_txns = 0;
    bit nack_addr = 0, stuck = 0;
    int nack_wbyte = -1;
    bit m_act = 0, m_rw = 0, m_stop = 0, m_addr_done = 0;
    int m_tmr = 0, m_wb = 0;

    i2c_register_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reg_addr(cmd_reg_addr), .cmd_length(cmd_length), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .error(error), .busy(busy),
        .i2c_idle(i2c_idle), .i2c_ack(i2c_ack), .i2c_nack(i2c_nack),
        .i2c_received_data(i2c_received_data), .i2c_address(i2c_address),
        .i2c_read_write(i2c_read_write), .i2c_transmit_data(i2c_transmit_data),
        .i2c_enable_transfer(i2c_enable_transfer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: address phase, then one byte every few cycles; enable sampled in the ack cycle.
    always @(posedge clk) begin
        i2c_ack <= 1'b0;
        i2c_nack <= 1'b0;
        if (reset) begin
            i2c_idle <= 1'b1;
            m_act = 0;
            m_stop = 0;
        end else if (!m_act) begin
            if (i2c_enable_transfer) begin
                m_act = 1;
                m_rw = i2c_read_write;
                m_tmr = 0;
                m_addr_done = 0;
                m_wb = 0;
                i2c_idle <= 1'b0;
                if (m_rw) rd_txns++; else wr_txns++;
            end
        end else if (m_stop) begin
            if (m_tmr >= 3) begin
                i2c_idle <= 1'b1;
                m_act = 0;
                m_stop = 0;
            end else m_tmr++;
        end else if (i2c_ack) begin
            m_tmr = 0;
            if (!i2c_enable_transfer) m_stop = 1;
        end else if (m_tmr < 4) m_tmr++;
        else if (!stuck) begin
            m_tmr = 0;
            if (!m_addr_done) begin
                if (nack_addr) begin
                    i2c_nack <= 1'b1;
                    m_stop = 1;
                    nack_addr = 0;
                end else m_addr_done = 1;
            end else if (!m_rw && m_wb == nack_wbyte) begin
                i2c_nack <= 1'b1;
                m_stop = 1;
                nack_wbyte = -1;
            end else begin
                i2c_ack <= 1'b1;
                if (m_rw) begin
                    i2c_received_data <= (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                    rd_total++;
                end else begin
                    if (exp_tx.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL tx_unexpected: observed=%0h expected=none", i2c_transmit_data);
                    end else chk("tx_byte", {24'd0, i2c_transmit_data}, {24'd0, exp_tx.pop_front()});
                    wr_total++;
                    m_wb++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (rd_valid) begin
            rv_cnt++;
            if (exp_rd.size() == 0) begin
                total++;
                bad++;
                $error("FAIL rd_unexpected: observed=%0h expected=none", rd_data);
            end else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
        end
    end

    task automatic clr();
        done_cnt = 0; err_cnt = 0; rv_cnt = 0;
        wr_total = 0; rd_total = 0; wr_txns = 0; rd_txns = 0;
    endtask

    task automatic issue(input logic [15:0] a, input logic [11:0] l);
        @(negedge clk);
        cmd_reg_addr = a;
        cmd_length = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ended_in_budget"}, 32'(n < budget), 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rw"}, 32'(i2c_read_write), 0);
        chk({tag, "_tx"}, 32'(i2c_transmit_data), 0);
        chk({tag, "_en"}, 32'(i2c_enable_transfer), 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_addr", 32'(i2c_address), 32'h33);
        reset = 1'b0;
        @(negedge clk);

        // Basic read of four bytes; a second request held during the command must be ignored.
        clr();
        rd_src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_rd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_tx = '{8'h24, 8'h00};
        @(negedge clk);
        cmd_reg_addr = 16'h2400;
        cmd_length = 12'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(cmd_ready), 0);
        cmd_reg_addr = 16'hFFFF;
        cmd_length = 12'd1;
        repeat (15) @(negedge clk);
        cmd_valid = 1'b0;
        wait_end("t1", 2000);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_rv_cnt", rv_cnt, 4);
        chk("t1_wr_txns", wr_txns, 1);
        chk("t1_rd_txns", rd_txns, 1);
        chk("t1_wr_bytes", wr_total, 2);
        chk("t1_rd_bytes", rd_total, 4);
        chk("t1_tx_left", exp_tx.size(), 0);
        chk("t1_rd_left", exp_rd.size(), 0);
        chk("t1_busy_end", 32'(busy), 0);

        // Pointer write only.
        clr();
        exp_tx = '{8'h80, 8'h0D};
        issue(16'h800D, 12'd0);
        wait_end("t2", 2000);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_err_cnt", err_cnt, 0);
        chk("t2_rv_cnt", rv_cnt, 0);
        chk("t2_rd_txns", rd_txns, 0);
        chk("t2_wr_bytes", wr_total, 2);
        chk("t2_tx_left", exp_tx.size(), 0);

        // Address NACK.
        clr();
        nack_addr = 1;
        issue(16'h4567, 12'd3);
        wait_end("t3", 2000);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_done_cnt", done_cnt, 0);
        chk("t3_wr_bytes", wr_total, 0);
        chk("t3_rd_txns", rd_txns, 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_ready", 32'(cmd_ready), 1);
        chk("t3_ctrl_idle", 32'(i2c_idle), 1);

        // NACK on the second pointer byte.
        clr();
        nack_wbyte = 1;
        exp_tx = '{8'h12};
        issue(16'h1234, 12'd2);
        wait_end("t4", 2000);
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_wr_bytes", wr_total, 1);
        chk("t4_rd_txns", rd_txns, 0);
        chk("t4_rv_cnt", rv_cnt, 0);
        chk("t4_tx_left", exp_tx.size(), 0);

        // Reset during the third of eight read bytes, then a fresh command.
        clr();
        for (int i = 0; i < 8; i++) begin
            rd_src.push_back(8'(i * 17 + 3));
            exp_rd.push_back(8'(i * 17 + 3));
        end
        exp_tx = '{8'h30, 8'h00};
        issue(16'h3000, 12'd8);
        begin
            int n = 0;
            while (rv_cnt < 2 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("t5_two_bytes_in_budget", 32'(n < 2000), 1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t5_rst");
        reset = 1'b0;
        rd_src.delete();
        exp_rd.delete();
        exp_tx.delete();
        clr();
        repeat (10) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_err", err_cnt, 0);
        rd_src = '{8'h5A, 8'hA5};
        exp_rd = '{8'h5A, 8'hA5};
        exp_tx = '{8'h01, 8'h02};
        issue(16'h0102, 12'd2);
        wait_end("t5b", 2000);
        chk("t5b_done_cnt", done_cnt, 1);
        chk("t5b_err_cnt", err_cnt, 0);
        chk("t5b_rv_cnt", rv_cnt, 2);
        chk("t5b_tx_left", exp_tx.size(), 0);
        chk("t5b_rd_left", exp_rd.size(), 0);

        // Hung controller: no watchdog in the default build, so busy stays high.
        clr();
        stuck = 1;
        issue(16'h0055, 12'd1);
        repeat (300) @(negedge clk);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_ready", 32'(cmd_ready), 0);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_done_cnt", done_cnt, 0);
        reset = 1'b1;
        stuck = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
